// File: rtl/spike_synapse.sv
// Weighted spike-integrating synapse. Leaky current accumulator with per-input
// signed weights, clamped to an unsigned 8-bit current, plus an event counter.
module spike_synapse #(
   parameter int                N_IN        = 4,
   parameter int                DECAY_SHIFT = 2,
   parameter logic signed [7:0] WEIGHT_INIT = 8'sd32,
   localparam int               AW          = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [N_IN-1:0] spike_in,
   input  logic            wt_wr,
   input  logic [AW-1:0]   wt_addr,
   input  logic [7:0]      wt_data,
   output logic [7:0]      current,
   output logic            sat_hi,
   output logic            sat_lo,
   output logic [7:0]      evt_cnt
);

   localparam int DATA_W  = 8;
   localparam int COEF_W  = 8;
   localparam int SUM_REQ = COEF_W + $clog2(N_IN + 1) + 2;
   localparam int ACC_W   = (SUM_REQ > 12) ? SUM_REQ : 12;

   localparam logic signed [ACC_W-1:0] U8_MAX = ACC_W'(255);
   localparam logic signed [ACC_W-1:0] U8_MIN = '0;

   logic signed [COEF_W-1:0] w [N_IN];

   logic [DATA_W-1:0]       leak_p0;
   logic signed [ACC_W-1:0] wsum_p0;
   logic signed [ACC_W-1:0] nxt_p0;
   logic [7:0]              pop_p0;
   logic                    wr_ok_p0;

   function automatic logic [DATA_W-1:0] sat_u8(input logic signed [ACC_W-1:0] v);
      if (v > U8_MAX)
         return {DATA_W{1'b1}};
      else if (v < U8_MIN)
         return '0;
      else
         return v[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] leak_of(input logic [DATA_W-1:0] c);
      logic [DATA_W-1:0] l;
      l = c >> DECAY_SHIFT;
      // A nonzero current always leaks by at least one so it reaches zero.
      if ((c != '0) && (l == '0))
         l = DATA_W'(1);
      return l;
   endfunction

   // Stage p0: leak, weighted spike sum and popcount from current state.
   always_comb begin
      leak_p0 = leak_of(current);
      wsum_p0 = '0;
      pop_p0  = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (spike_in[i]) begin
            wsum_p0 = wsum_p0 + ACC_W'(w[i]);
            pop_p0  = pop_p0 + 8'(spike_in[i]);
         end
      end
      nxt_p0   = $signed(ACC_W'(current)) - $signed(ACC_W'(leak_p0)) + wsum_p0;
      wr_ok_p0 = wt_wr && (32'(wt_addr) < N_IN);
   end

   // Registered outputs; weights written after this edge's sum used the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current <= '0;
         sat_hi  <= 1'b0;
         sat_lo  <= 1'b0;
         evt_cnt <= '0;
         for (int i = 0; i < N_IN; i++)
            w[i] <= WEIGHT_INIT;
      end else begin
         if (ena) begin
            current <= sat_u8(nxt_p0);
            sat_hi  <= (nxt_p0 > U8_MAX);
            sat_lo  <= (nxt_p0 < U8_MIN);
            evt_cnt <= evt_cnt + pop_p0;
         end
         if (wr_ok_p0)
            w[wt_addr] <= $signed(wt_data);
      end
   end

endmodule
